// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg
//   Shared CPU-side types. Holds the RAM status encoding used by the memory
//   model and the cache/memory arbiter's FSM and grant types.
//   No ports (package).
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  // RAM port status as reported by the memory model.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Arbiter FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DGRANT = 2'd1,
    IGRANT = 2'd2
  } arb_state_t;

  // Which requester held the most recent grant.
  typedef enum logic {
    GRANT_D = 1'b0,
    GRANT_I = 1'b1
  } grant_t;

  localparam word_t WORD_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/sat_counter32.sv
// sat_counter32
//   32-bit up counter with enable that holds at all-ones instead of wrapping.
//   Ports:
//     clk    in   clock
//     n_rst  in   asynchronous active-low reset (clears count)
//     en     in   count enable
//     count  out  current count
module sat_counter32
  import cpu_types_pkg::*;
(
  input  logic  clk,
  input  logic  n_rst,
  input  logic  en,
  output word_t count
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (en && (count != WORD_MAX)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Responder end of the cache-to-memory protocol. Arbitrates icache
//   (read-only) and dcache (read/write, multi-word blocks) requests onto the
//   single RAM port and returns data with per-requester wait signals.
//
//   Optional feature macro: ARB_STATS_EN
//     defined   -> dword_cnt / iword_cnt count completed words (saturating)
//     undefined -> both count ports are tied to 0, no counter flops
//
//   Ports:
//     clk, n_rst            clock, asynchronous active-low reset
//     iREN, iaddr           icache read request / word address
//     iwait, iload          icache wait (low = iload valid) / read data
//     dREN, dWEN            dcache read / write request
//     daddr, dstore         dcache word address / write data
//     dwait, dload          dcache wait (low = word done) / read data
//     ramREN, ramWEN        RAM read / write strobes
//     ramaddr, ramstore     RAM address / write data
//     ramload, ramstate     RAM read data / RAM status
//     ram_err               sticky: RAM reported ERROR during a grant
//     dword_cnt, iword_cnt  completed word counters (stats build)
//     arb_state             current FSM state, for observation
//
//   Handshake: a requester raises its request with address (and write data)
//   and holds them stable while its wait is high. The cycle wait is low is the
//   completion of that word; the requester may then present the next word of
//   the same block with the request still high, or drop the request to
//   release the grant. Dropping the request while wait is high abandons the
//   word.
module cache_mem_arbiter
  import cpu_types_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       iREN,
  input  word_t      iaddr,
  output logic       iwait,
  output word_t      iload,
  input  logic       dREN,
  input  logic       dWEN,
  input  word_t      daddr,
  input  word_t      dstore,
  output logic       dwait,
  output word_t      dload,
  output logic       ramREN,
  output logic       ramWEN,
  output word_t      ramaddr,
  output word_t      ramstore,
  input  word_t      ramload,
  input  ramstate_t  ramstate,
  output logic       ram_err,
  output word_t      dword_cnt,
  output word_t      iword_cnt,
  output arb_state_t arb_state
);

  arb_state_t state_q, state_d;
  grant_t     last_grant_q;
  logic       ram_err_q;
  logic       d_req;
  logic       ram_done;

  assign d_req    = dREN | dWEN;
  assign ram_done = (ramstate == ACCESS);

  // Next-state logic. A grant is held for as long as its requester keeps the
  // request up, so a dcache writeback followed by its refill stays atomic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (d_req && iREN) begin
          // Tie: round-robin against whoever was served last.
          state_d = (last_grant_q == GRANT_I) ? DGRANT : IGRANT;
        end else if (d_req) begin
          state_d = DGRANT;
        end else if (iREN) begin
          state_d = IGRANT;
        end
      end
      DGRANT:  if (!d_req) state_d = IDLE;
      IGRANT:  if (!iREN)  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      ram_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == DGRANT && !d_req) last_grant_q <= GRANT_D;
      if (state_q == IGRANT && !iREN)  last_grant_q <= GRANT_I;
      if (state_q != IDLE && ramstate == ERROR) ram_err_q <= 1'b1;
    end
  end

  // RAM port and wait outputs decode directly from the registered state, so
  // an asynchronous reset drops the strobes immediately.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    case (state_q)
      DGRANT: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else if (dREN) begin
          ramREN = 1'b1;
        end
        dwait = !ram_done;
      end
      IGRANT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
        iwait   = !ram_done;
      end
      default: begin
      end
    endcase
  end

  assign iload     = ramload;
  assign dload     = ramload;
  assign ram_err   = ram_err_q;
  assign arb_state = state_q;

`ifdef ARB_STATS_EN
  logic d_word_done;
  logic i_word_done;

  assign d_word_done = (state_q == DGRANT) && ram_done;
  assign i_word_done = (state_q == IGRANT) && ram_done;

  sat_counter32 u_dword_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (d_word_done),
    .count (dword_cnt)
  );

  sat_counter32 u_iword_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (i_word_done),
    .count (iword_cnt)
  );
`else
  assign dword_cnt = '0;
  assign iword_cnt = '0;
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
//   Directed bench for cache_mem_arbiter. The bench plays both caches and the
//   RAM model; read data comes from a fixed address pattern and is queued
//   when the bench drives ACCESS, then popped when the matching wait is low.
module tb_cache_mem_arbiter;
  import cpu_types_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic       iREN = 1'b0;
  word_t      iaddr = '0;
  logic       dREN = 1'b0;
  logic       dWEN = 1'b0;
  word_t      daddr = '0;
  word_t      dstore = '0;
  word_t      ramload = '0;
  ramstate_t  ramstate = FREE;

  logic       iwait, dwait, ramREN, ramWEN, ram_err;
  word_t      iload, dload, ramaddr, ramstore, dword_cnt, iword_cnt;
  arb_state_t st_dbg;

  cache_mem_arbiter dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .iREN      (iREN),
    .iaddr     (iaddr),
    .iwait     (iwait),
    .iload     (iload),
    .dREN      (dREN),
    .dWEN      (dWEN),
    .daddr     (daddr),
    .dstore    (dstore),
    .dwait     (dwait),
    .dload     (dload),
    .ramREN    (ramREN),
    .ramWEN    (ramWEN),
    .ramaddr   (ramaddr),
    .ramstore  (ramstore),
    .ramload   (ramload),
    .ramstate  (ramstate),
    .ram_err   (ram_err),
    .dword_cnt (dword_cnt),
    .iword_cnt (iword_cnt),
    .arb_state (st_dbg)
  );

  // scoreboard
  int    n_checks = 0;
  int    n_fail = 0;
  word_t exp_q[$];
  word_t exp_dcnt = '0;
  word_t exp_icnt = '0;

  function automatic word_t mem_word(input word_t addr);
    return addr ^ 32'hA5A5_0000;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " state"}, 32'(st_dbg), 32'(IDLE));
    chk({tag, " ramREN"}, 32'(ramREN), 32'd0);
    chk({tag, " ramWEN"}, 32'(ramWEN), 32'd0);
    chk({tag, " iwait"}, 32'(iwait), 32'd1);
    chk({tag, " dwait"}, 32'(dwait), 32'd1);
    chk({tag, " ramaddr"}, ramaddr, 32'd0);
    chk({tag, " ramstore"}, ramstore, 32'd0);
  endtask

  task automatic check_counts(input string tag);
`ifdef ARB_STATS_EN
    chk({tag, " dword_cnt"}, dword_cnt, exp_dcnt);
    chk({tag, " iword_cnt"}, iword_cnt, exp_icnt);
`else
    chk({tag, " dword_cnt"}, dword_cnt, 32'd0);
    chk({tag, " iword_cnt"}, iword_cnt, 32'd0);
`endif
  endtask

  // Serve one word of the current grant: one BUSY cycle, then ACCESS.
  // Entered just after a clock edge with the grant state active and the
  // requester's address/data already driven; returns just after the edge
  // that completes the word.
  task automatic serve_word(input string tag, input logic dside,
                            input logic is_write, input word_t addr,
                            input word_t data);
    word_t exp_d;
    chk({tag, " grant"}, 32'(st_dbg), dside ? 32'(DGRANT) : 32'(IGRANT));
    ramstate = BUSY;
    #1;
    chk({tag, " ramaddr"}, ramaddr, addr);
    chk({tag, " wait busy"}, 32'(dside ? dwait : iwait), 32'd1);
    chk({tag, " other wait"}, 32'(dside ? iwait : dwait), 32'd1);
    if (is_write) begin
      chk({tag, " ramWEN"}, 32'(ramWEN), 32'd1);
      chk({tag, " ramREN"}, 32'(ramREN), 32'd0);
      chk({tag, " ramstore"}, ramstore, data);
    end else begin
      chk({tag, " ramREN"}, 32'(ramREN), 32'd1);
      chk({tag, " ramWEN"}, 32'(ramWEN), 32'd0);
    end
    tick();
    ramstate = ACCESS;
    if (is_write) begin
      ramload = 32'hDEAD_BEEF;
    end else begin
      ramload = data;
      exp_q.push_back(data);
    end
    #1;
    chk({tag, " wait low"}, 32'(dside ? dwait : iwait), 32'd0);
    if (is_write) begin
      chk({tag, " ramstore acc"}, ramstore, data);
    end else begin
      exp_d = exp_q.pop_front();
      chk({tag, " load"}, dside ? dload : iload, exp_d);
    end
    tick();
    if (dside) exp_dcnt++;
    else       exp_icnt++;
    ramstate = FREE;
    check_counts(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    word_t exp_d;

    // reset state
    #1;
    check_idle("rst");
    chk("rst ram_err", 32'(ram_err), 32'd0);
    check_counts("rst");
    repeat (2) tick();
    n_rst = 1'b1;
    repeat (2) tick();
    check_idle("idle");

    // single icache read, ACCESS one cycle after ramREN
    iREN = 1'b1;
    iaddr = 32'h40;
    #1;
    chk("ird cyc0 state", 32'(st_dbg), 32'(IDLE));
    tick();
    #1;
    chk("ird state", 32'(st_dbg), 32'(IGRANT));
    chk("ird ramREN", 32'(ramREN), 32'd1);
    chk("ird ramaddr", ramaddr, 32'h40);
    chk("ird iwait pre", 32'(iwait), 32'd1);
    tick();
    ramstate = ACCESS;
    ramload = 32'hCAFE_0001;
    exp_q.push_back(32'hCAFE_0001);
    #1;
    chk("ird iwait low", 32'(iwait), 32'd0);
    exp_d = exp_q.pop_front();
    chk("ird iload", iload, exp_d);
    tick();
    exp_icnt++;
    iREN = 1'b0;
    ramstate = FREE;
    #1;
    chk("ird iwait post", 32'(iwait), 32'd1);
    check_counts("ird");
    tick();
    check_idle("ird end");

    // asynchronous reset in the middle of a write grant
    dWEN = 1'b1;
    daddr = 32'h500;
    dstore = 32'h0000_0055;
    tick();
    chk("mrst ramWEN", 32'(ramWEN), 32'd1);
    n_rst = 1'b0;
    #1;
    chk("mrst ramWEN drop", 32'(ramWEN), 32'd0);
    chk("mrst ramREN", 32'(ramREN), 32'd0);
    chk("mrst state", 32'(st_dbg), 32'(IDLE));
    exp_dcnt = '0;
    exp_icnt = '0;
    check_counts("mrst");
    dWEN = 1'b0;
    tick();
    n_rst = 1'b1;
    tick();

    // first tie out of reset goes to the dcache
    dREN = 1'b1;
    daddr = 32'h300;
    iREN = 1'b1;
    iaddr = 32'h44;
    tick();
    serve_word("tie1 d", 1'b1, 1'b0, 32'h300, mem_word(32'h300));
    dREN = 1'b0;
    iREN = 1'b0;
    tick();
    chk("tie1 end", 32'(st_dbg), 32'(IDLE));

    // next tie after a D grant goes to the icache
    dREN = 1'b1;
    daddr = 32'h304;
    iREN = 1'b1;
    iaddr = 32'h48;
    tick();
    serve_word("tie2 i", 1'b0, 1'b0, 32'h48, mem_word(32'h48));
    dREN = 1'b0;
    iREN = 1'b0;
    tick();
    chk("tie2 end", 32'(st_dbg), 32'(IDLE));

    // writeback + refill held as one grant with iREN continuously high
    dWEN = 1'b1;
    daddr = 32'h100;
    dstore = 32'h1111_0100;
    iREN = 1'b1;
    iaddr = 32'h4C;
    tick();
    serve_word("wb0", 1'b1, 1'b1, 32'h100, 32'h1111_0100);
    daddr = 32'h104;
    dstore = 32'h1111_0104;
    serve_word("wb1", 1'b1, 1'b1, 32'h104, 32'h1111_0104);
    dWEN = 1'b0;
    dREN = 1'b1;
    daddr = 32'h200;
    serve_word("rf0", 1'b1, 1'b0, 32'h200, mem_word(32'h200));
    daddr = 32'h204;
    serve_word("rf1", 1'b1, 1'b0, 32'h204, mem_word(32'h204));
    dREN = 1'b0;
    tick();
    chk("wb bubble", 32'(st_dbg), 32'(IDLE));
    chk("wb bubble iwait", 32'(iwait), 32'd1);
    tick();
    serve_word("wb igrant", 1'b0, 1'b0, 32'h4C, mem_word(32'h4C));
    iREN = 1'b0;
    tick();
    chk("wb end", 32'(st_dbg), 32'(IDLE));

    // dREN and dWEN together: write wins; then ERROR is sticky
    dREN = 1'b1;
    dWEN = 1'b1;
    daddr = 32'h80;
    dstore = 32'h1234_5678;
    tick();
    #1;
    chk("rw ramWEN", 32'(ramWEN), 32'd1);
    chk("rw ramREN", 32'(ramREN), 32'd0);
    chk("rw ramstore", ramstore, 32'h1234_5678);
    chk("rw ramaddr", ramaddr, 32'h80);
    tick();
    ramstate = ERROR;
    #1;
    chk("err dwait", 32'(dwait), 32'd1);
    chk("err ram_err pre", 32'(ram_err), 32'd0);
    tick();
    ramstate = BUSY;
    #1;
    chk("err ram_err set", 32'(ram_err), 32'd1);
    chk("err dwait busy", 32'(dwait), 32'd1);
    check_counts("err");
    tick();
    ramstate = ACCESS;
    #1;
    chk("err dwait acc", 32'(dwait), 32'd0);
    chk("err ram_err acc", 32'(ram_err), 32'd1);
    tick();
    exp_dcnt++;
    ramstate = FREE;
    dREN = 1'b0;
    dWEN = 1'b0;
    #1;
    chk("err ram_err hold", 32'(ram_err), 32'd1);
    check_counts("err acc");
    tick();
    chk("err end", 32'(st_dbg), 32'(IDLE));

    // request dropped while wait is high: back to IDLE, nothing counted
    iREN = 1'b1;
    iaddr = 32'h60;
    tick();
    ramstate = BUSY;
    #1;
    chk("drop iwait", 32'(iwait), 32'd1);
    iREN = 1'b0;
    tick();
    ramstate = FREE;
    #1;
    chk("drop state", 32'(st_dbg), 32'(IDLE));
    check_counts("drop");
    chk("drop ram_err", 32'(ram_err), 32'd1);

    chk("queue empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
